tlc_param_ctrl: RTL and testbench

- Parametrised successor to the two-road highway/farm traffic-light FSM.
- Adds configurable dwell times, highway minimum green, farm green extension (min/max), all-red clearance, a latched pedestrian request with walk output, input synchronisers and a tick enable.
- Sits at the top of the design behind the tiny-tapeout wrapper; drives the lamp outputs directly.

---
 rtl/tlc_param_ctrl.sv | 76 +++++++
 tb/tb_tlc_param_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/tlc_param_ctrl.sv
// tlc_param_ctrl: highway/farm traffic-light controller with configurable dwells, pedestrian walk and input synchronisers
module tlc_param_ctrl #(
    parameter int CNT_W          = 8,
    parameter int HWY_MIN_GREEN  = 20,
    parameter int FARM_MIN_GREEN = 5,
    parameter int FARM_MAX_GREEN = 12,
    parameter int YELLOW_T       = 3,
    parameter int ALL_RED_T      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       car_sense,
    input  logic       ped_req,
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    output logic       ped_walk,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        HGRE  = 3'd0,
        HYEL  = 3'd1,
        ARED1 = 3'd2,
        FGRE  = 3'd3,
        FYEL  = 3'd4,
        ARED2 = 3'd5
    } state_t;
    localparam logic [CNT_W-1:0] HWY_LAST  = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] FMIN_LAST = CNT_W'(FARM_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] FMAX_LAST = CNT_W'(FARM_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(ALL_RED_T - 1);
    state_t           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic             car_q, car_s, ped_q, ped_s, ped_pending;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HGRE;
            timer       <= '0;
            ped_pending <= 1'b0;
            car_q       <= 1'b0;
            car_s       <= 1'b0;
            ped_q       <= 1'b0;
            ped_s       <= 1'b0;
        end else begin
            car_q       <= car_sense;
            car_s       <= car_q;
            ped_q       <= ped_req;
            ped_s       <= ped_q;
            state       <= state_nx;
            timer       <= timer_nx;
            ped_pending <= (state_nx == FGRE && state != FGRE) ? 1'b0 :
                           (ped_s && state != FGRE) ? 1'b1 : ped_pending;
        end
    end
    // undefined codes fall to default and recover without waiting for ena
    always_comb begin
        state_nx = state;
        case (state)
            HGRE:  if (ena && timer >= HWY_LAST && (car_s || ped_pending)) state_nx = HYEL;
            HYEL:  if (ena && timer == YEL_LAST) state_nx = ARED1;
            ARED1: if (ena && timer == RED_LAST) state_nx = FGRE;
            FGRE:  if (ena && (timer == FMAX_LAST || (timer >= FMIN_LAST && !car_s))) state_nx = FYEL;
            FYEL:  if (ena && timer == YEL_LAST) state_nx = ARED2;
            ARED2: if (ena && timer == RED_LAST) state_nx = HGRE;
            default: state_nx = HGRE;
        endcase
    end
    assign timer_nx = (state_nx != state) ? '0 :
                      !ena ? timer :
                      (state == HGRE && timer >= HWY_LAST) ? timer : timer + 1'b1;
    assign light_highway = state == HGRE ? 3'b001 : state == HYEL ? 3'b010 : 3'b100;
    assign light_farm    = state == FGRE ? 3'b001 : state == FYEL ? 3'b010 : 3'b100;
    assign ped_walk      = state == FGRE;
    assign state_o       = state;
endmodule

// File: tb/tb_tlc_param_ctrl.sv
// tb_tlc_param_ctrl: directed checks of tlc_param_ctrl with short dwell parameters
module tb_tlc_param_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, ena, car_sense, ped_req;
    logic [2:0] light_highway, light_farm, state_o;
    logic       ped_walk;
    int         total = 0;
    int         bad = 0;
    int         en_cnt;
    int         exp3 [1:25] = '{0,0,0,0,0,0,0,0,0,0,0,1,1,2,3,3,3,4,4,5,0,0,0,0,0};
    int         exp4 [1:20] = '{0,0,0,0,0,0,0,0,1,1,2,3,3,3,4,4,5,0,0,0};
    int         pat  [0:15] = '{1,1,2,3,3,3,3,3,3,4,4,5,0,0,0,0};

    tlc_param_ctrl #(
        .CNT_W(8), .HWY_MIN_GREEN(4), .FARM_MIN_GREEN(3),
        .FARM_MAX_GREEN(6), .YELLOW_T(2), .ALL_RED_T(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .car_sense(car_sense), .ped_req(ped_req),
        .light_highway(light_highway), .light_farm(light_farm),
        .ped_walk(ped_walk), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] lamps(input int s);
        case (s)
            0: lamps = {3'b001, 3'b100, 1'b0, 3'd0};
            1: lamps = {3'b010, 3'b100, 1'b0, 3'd1};
            2: lamps = {3'b100, 3'b100, 1'b0, 3'd2};
            3: lamps = {3'b100, 3'b001, 1'b1, 3'd3};
            4: lamps = {3'b100, 3'b010, 1'b0, 3'd4};
            default: lamps = {3'b100, 3'b100, 1'b0, 3'd5};
        endcase
    endfunction

    function automatic int seq(input int n);
        seq = (n <= 3) ? 0 : pat[(n - 4) % 16];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_st(input string tag, input int s);
        chk(tag, {22'd0, light_highway, light_farm, ped_walk, state_o}, {22'd0, lamps(s)});
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b1; car_sense = 1'b0; ped_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // reset values
        rst_n = 1'b0; ena = 1'b1; car_sense = 1'b0; ped_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_st("reset_lamps", 0);
        chk("reset_timer", 32'(dut.timer), 0);
        chk("reset_pend", 32'(dut.ped_pending), 0);
        rst_n = 1'b1;
        // idle: HGRE holds indefinitely
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            chk_st($sformatf("idle_%0d", i), 0);
        end
        chk("idle_timer_sat", 32'(dut.timer), 3);
        // car held: full cycle with farm max-out, repeated
        do_reset();
        car_sense = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            chk_st($sformatf("car_held_%0d", i), seq(i));
        end
        // car pulse: farm green ends at min green
        do_reset();
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            chk_st($sformatf("car_pulse_%0d", i), exp3[i]);
            if (i == 9) car_sense = 1'b1;
            if (i == 12) car_sense = 1'b0;
        end
        // pedestrian pulse
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk_st($sformatf("ped_%0d", i), exp4[i]);
            if (i == 7) chk("ped_pend_e7", 32'(dut.ped_pending), 0);
            if (i == 8) chk("ped_pend_e8", 32'(dut.ped_pending), 1);
            if (i == 11) chk("ped_pend_e11", 32'(dut.ped_pending), 1);
            if (i == 12) chk("ped_pend_e12", 32'(dut.ped_pending), 0);
            if (i == 5) ped_req = 1'b1;
            if (i == 6) ped_req = 1'b0;
        end
        // ena toggling under car held: progress follows enabled edges only
        do_reset();
        car_sense = 1'b1;
        en_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            ena = (i % 2) == 1;
            @(negedge clk);
            if (ena) en_cnt++;
            chk_st($sformatf("ena_tog_%0d", i), seq(en_cnt));
        end
        ena = 1'b1;
        // reset in FGRE with timer=2
        do_reset();
        car_sense = 1'b1;
        repeat (9) @(negedge clk);
        chk_st("fgre_before_rst", 3);
        chk("fgre_timer", 32'(dut.timer), 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        car_sense = 1'b0;
        chk_st("mid_rst_lamps", 0);
        chk("mid_rst_timer", 32'(dut.timer), 0);
        chk("mid_rst_pend", 32'(dut.ped_pending), 0);
        // pending pedestrian request discarded by reset
        do_reset();
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("pend_before_rst", 32'(dut.ped_pending), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("pend_after_rst", 32'(dut.ped_pending), 0);
        chk_st("pend_rst_lamps", 0);
        repeat (10) @(negedge clk);
        chk_st("pend_discarded", 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
